// File: rtl/fifo_pkg.sv
// Shared types for the stream_advance block: the sequencing FSM state encoding.
package fifo_pkg;

  typedef enum logic [1:0] {
    SKIP = 2'd0,
    PASS = 2'd1,
    PAD  = 2'd2
  } state_e;

endpackage

// File: rtl/pipe_stage.sv
// One register stage of the output pipeline, carrying valid, last and data.
// Data is only loaded on valid beats, so it holds its value while the stage is idle.
module pipe_stage #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             i_valid,
  input  logic             i_last,
  input  logic [WIDTH-1:0] i_data,
  output logic             o_valid,
  output logic             o_last,
  output logic [WIDTH-1:0] o_data
);

  logic             r_valid;
  logic             r_last;
  logic [WIDTH-1:0] r_data;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of block ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= 1'b0;
      r_last  <= 1'b0;
      r_data  <= '0;
    end else if (flush) begin
      r_valid <= 1'b0;
      r_last  <= 1'b0;
    end else begin
      r_valid <= i_valid;
      r_last  <= i_valid & i_last;
      if (i_valid) r_data <= i_data;
    end
  end

  assign o_valid = r_valid;
  assign o_last  = r_last;
  assign o_data  = r_data;

endmodule

// File: rtl/stream_advance.sv
// Drops the first `advance` samples of each stream and pads the tail with zero
// beats so every stream leaves with as many beats as it arrived with.
module stream_advance
  import fifo_pkg::*;
#(
  parameter int MAX_ADVANCE = 128,
  parameter int WIDTH       = 32,
  parameter int FLUSH       = 1
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [WIDTH-1:0]               data_in,
  input  logic                           valid_in,
  input  logic                           last_in,
  input  logic [$clog2(MAX_ADVANCE)-1:0] advance,
  input  logic                           flush,
  output logic [WIDTH-1:0]               data_out,
  output logic                           valid_out,
  output logic                           last_out,
  output logic                           busy,
  output logic                           overrun
);

  localparam int ADV_W = $clog2(MAX_ADVANCE);
  localparam logic [ADV_W-1:0] CNT_ONE = ADV_W'(1);

  state_e           r_state;
  logic [ADV_W-1:0] r_cnt;
  logic [ADV_W-1:0] r_adv;
  logic [ADV_W-1:0] r_pad_cnt;
  logic             r_overrun;

  state_e           w_state_nxt;
  logic [ADV_W-1:0] w_cnt_nxt;
  logic [ADV_W-1:0] w_adv_nxt;
  logic [ADV_W-1:0] w_pad_nxt;
  logic             w_overrun_nxt;
  logic [ADV_W-1:0] w_adv_eff;
  logic             w_flush;

  logic             w_s1_valid;
  logic             w_s1_last;
  logic [WIDTH-1:0] w_s1_data;
  logic             w_p1_valid;
  logic             w_p1_last;
  logic [WIDTH-1:0] w_p1_data;
  logic             w_p2_valid;
  logic             w_p2_last;
  logic [WIDTH-1:0] w_p2_data;

  assign w_flush = (FLUSH != 0) && flush;

  // The first sample of a stream compares against the live advance input,
  // since adv_q is only being loaded on that same edge.
  assign w_adv_eff = (r_cnt == '0) ? advance : r_adv;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= SKIP;
      r_cnt     <= '0;
      r_adv     <= '0;
      r_pad_cnt <= '0;
      r_overrun <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_adv     <= w_adv_nxt;
      r_pad_cnt <= w_pad_nxt;
      r_overrun <= w_overrun_nxt;
    end
  end

  // NOTE: every signal driven here gets a default first, so no path through
  // the case statement can leave one unassigned and infer a latch.
  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_cnt;
    w_adv_nxt     = r_adv;
    w_pad_nxt     = r_pad_cnt;
    w_overrun_nxt = r_overrun;
    w_s1_valid    = 1'b0;
    w_s1_last     = 1'b0;
    w_s1_data     = '0;

    if (w_flush) begin
      w_state_nxt   = SKIP;
      w_cnt_nxt     = '0;
      w_pad_nxt     = '0;
      w_overrun_nxt = 1'b0;
    end else begin
      unique case (r_state)
        SKIP: begin
          if (valid_in) begin
            if (r_cnt == '0) w_adv_nxt = advance;
            if (r_cnt != w_adv_eff) begin
              w_cnt_nxt = r_cnt + 1'b1;
              if (last_in) begin
                // Stream ended while still dropping: pad one zero per drop.
                w_pad_nxt   = r_cnt + 1'b1;
                w_cnt_nxt   = '0;
                w_state_nxt = PAD;
              end
            end else begin
              w_cnt_nxt   = '0;
              w_state_nxt = PASS;
              w_s1_valid  = 1'b1;
              w_s1_data   = data_in;
              if (last_in) begin
                w_pad_nxt = r_cnt;
                if (r_cnt == '0) begin
                  w_state_nxt = SKIP;
                  w_s1_last   = 1'b1;
                end else begin
                  w_state_nxt = PAD;
                end
              end
            end
          end
        end

        PASS: begin
          if (valid_in) begin
            w_s1_valid = 1'b1;
            w_s1_data  = data_in;
            if (last_in) begin
              w_pad_nxt = r_adv;
              if (r_adv == '0) begin
                w_state_nxt = SKIP;
                w_s1_last   = 1'b1;
              end else begin
                w_state_nxt = PAD;
              end
            end
          end
        end

        PAD: begin
          w_s1_valid = 1'b1;
          w_pad_nxt  = r_pad_cnt - 1'b1;
          if (valid_in) w_overrun_nxt = 1'b1;
          if (r_pad_cnt <= CNT_ONE) begin
            w_s1_last   = 1'b1;
            w_pad_nxt   = '0;
            w_cnt_nxt   = '0;
            w_state_nxt = SKIP;
          end
        end

        default: w_state_nxt = SKIP;
      endcase
    end
  end

  pipe_stage #(.WIDTH(WIDTH)) u_stage1 (
    .clk     (clk),
    .rst_n   (rst_n),
    .flush   (w_flush),
    .i_valid (w_s1_valid),
    .i_last  (w_s1_last),
    .i_data  (w_s1_data),
    .o_valid (w_p1_valid),
    .o_last  (w_p1_last),
    .o_data  (w_p1_data)
  );

  pipe_stage #(.WIDTH(WIDTH)) u_stage2 (
    .clk     (clk),
    .rst_n   (rst_n),
    .flush   (w_flush),
    .i_valid (w_p1_valid),
    .i_last  (w_p1_last),
    .i_data  (w_p1_data),
    .o_valid (w_p2_valid),
    .o_last  (w_p2_last),
    .o_data  (w_p2_data)
  );

  assign data_out  = w_p2_data;
  assign valid_out = w_p2_valid;
  assign last_out  = w_p2_last;
  assign busy      = (r_state == PAD);
  assign overrun   = r_overrun;

endmodule
